// File: rtl/apb_node_pkg.sv
// rtl/apb_node_pkg.sv - shared state and response types for the APB interconnect node
package apb_node_pkg;

    localparam int APB_NODE_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } node_state_e;

    typedef struct packed {
        logic [APB_NODE_DATA_W-1:0] rdata;
        logic                       err;
    } resp_cap_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - inclusive-range address decoder, lowest slot index wins
module apb_addr_decoder
    import apb_node_pkg::*;
#(
    parameter int NB_SLAVE       = 8,
    parameter int APB_ADDR_WIDTH = 32
) (
    input  logic [APB_ADDR_WIDTH-1:0]          addr_i,
    input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] end_addr_i,
    output logic [NB_SLAVE-1:0]                sel_o,
    output logic                               miss_o
);

    // Scanning from the top down lets the lowest hitting slot overwrite the rest.
    always_comb begin
        sel_o  = '0;
        miss_o = 1'b1;
        for (int k = NB_SLAVE - 1; k >= 0; k--) begin
            if ((start_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] <= addr_i) &&
                (addr_i <= end_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
                sel_o    = '0;
                sel_o[k] = 1'b1;
                miss_o   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_node_reg.sv
// rtl/apb_node_reg.sv - registered APB 1-to-NB_SLAVE node; APB_NODE_TIMEOUT_EN adds an ACCESS timeout
module apb_node_reg
    import apb_node_pkg::*;
#(
    parameter int NB_SLAVE       = 8,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               psel_i,
    input  logic                               penable_i,
    input  logic                               pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]          paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]          pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]          prdata_o,
    output logic                               pready_o,
    output logic                               pslverr_o,
    output logic [NB_SLAVE-1:0]                psel_o,
    output logic [NB_SLAVE-1:0]                penable_o,
    output logic [NB_SLAVE-1:0]                pwrite_o,
    output logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [NB_SLAVE*APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic [NB_SLAVE*APB_DATA_WIDTH-1:0] prdata_i,
    input  logic [NB_SLAVE-1:0]                pready_i,
    input  logic [NB_SLAVE-1:0]                pslverr_i,
    input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] START_ADDR_i,
    input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] END_ADDR_i
);

    node_state_e                state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                       write_q, write_d;
    logic [NB_SLAVE-1:0]        sel_q, sel_d;
    resp_cap_t                  cap_q, cap_d;

    logic [NB_SLAVE-1:0]        dec_sel;
    logic                       dec_miss;
    logic                       slv_ready;
    logic                       slv_err;
    logic [APB_DATA_WIDTH-1:0]  slv_rdata;

`ifdef APB_NODE_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]             cnt_q, cnt_d;
`endif

    // Decoded in the latching cycle so the select is captured alongside the address.
    apb_addr_decoder #(
        .NB_SLAVE       (NB_SLAVE),
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH)
    ) u_decoder (
        .addr_i       (paddr_i),
        .start_addr_i (START_ADDR_i),
        .end_addr_i   (END_ADDR_i),
        .sel_o        (dec_sel),
        .miss_o       (dec_miss)
    );

    always_comb begin
        slv_ready = |(pready_i & sel_q);
        slv_err   = |(pslverr_i & sel_q);
        slv_rdata = '0;
        for (int k = 0; k < NB_SLAVE; k++) begin
            slv_rdata = slv_rdata | (prdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH] & {APB_DATA_WIDTH{sel_q[k]}});
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        sel_d   = sel_q;
        cap_d   = cap_q;
`ifdef APB_NODE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    addr_d  = paddr_i;
                    wdata_d = pwdata_i;
                    write_d = pwrite_i;
                    sel_d   = dec_sel;
                    if (dec_miss) begin
                        cap_d.rdata = '0;
                        cap_d.err   = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_NODE_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: begin
                if (slv_ready) begin
                    cap_d.rdata = write_q ? '0 : APB_NODE_DATA_W'(slv_rdata);
                    cap_d.err   = slv_err;
                    state_d     = RESP;
`ifdef APB_NODE_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    cap_d.rdata = '0;
                    cap_d.err   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            sel_q   <= '0;
            cap_q   <= '0;
`ifdef APB_NODE_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            sel_q   <= sel_d;
            cap_q   <= cap_d;
`ifdef APB_NODE_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Every output is a pure decode of flops, so all drop together on reset.
    always_comb begin
        psel_o    = '0;
        penable_o = '0;
        pwrite_o  = '0;
        paddr_o   = '0;
        pwdata_o  = '0;
        for (int k = 0; k < NB_SLAVE; k++) begin
            if (((state_q == SETUP) || (state_q == ACCESS)) && sel_q[k]) begin
                psel_o[k]    = 1'b1;
                penable_o[k] = (state_q == ACCESS);
                pwrite_o[k]  = write_q;
                paddr_o[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]  = addr_q;
                pwdata_o[k*APB_DATA_WIDTH +: APB_DATA_WIDTH] = wdata_q;
            end
        end
        pready_o  = (state_q == RESP);
        pslverr_o = pready_o & cap_q.err;
        prdata_o  = pready_o ? APB_DATA_WIDTH'(cap_q.rdata) : '0;
    end

endmodule

// File: tb/tb_apb_node_reg.sv
// tb/tb_apb_node_reg.sv - self-checking bench for apb_node_reg against a timeline reference model
module tb_apb_node_reg;

    localparam int NB = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              psel_i, penable_i, pwrite_i;
    logic [AW-1:0]     paddr_i;
    logic [DW-1:0]     pwdata_i;
    logic [DW-1:0]     prdata_o;
    logic              pready_o, pslverr_o;
    logic [NB-1:0]     psel_o, penable_o, pwrite_o;
    logic [NB*AW-1:0]  paddr_o;
    logic [NB*DW-1:0]  pwdata_o;
    logic [NB*DW-1:0]  prdata_i;
    logic [NB-1:0]     pready_i, pslverr_i;
    logic [NB*AW-1:0]  START_ADDR_i, END_ADDR_i;

    logic [AW-1:0]     start_a [NB];
    logic [AW-1:0]     end_a   [NB];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int j = 0; j < NB; j++) begin
            START_ADDR_i[j*AW +: AW] = start_a[j];
            END_ADDR_i[j*AW +: AW]   = end_a[j];
        end
    end

    apb_node_reg #(
        .NB_SLAVE       (NB),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .psel_i       (psel_i),
        .penable_i    (penable_i),
        .pwrite_i     (pwrite_i),
        .paddr_i      (paddr_i),
        .pwdata_i     (pwdata_i),
        .prdata_o     (prdata_o),
        .pready_o     (pready_o),
        .pslverr_o    (pslverr_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .paddr_o      (paddr_o),
        .pwdata_o     (pwdata_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i),
        .pslverr_i    (pslverr_i),
        .START_ADDR_i (START_ADDR_i),
        .END_ADDR_i   (END_ADDR_i)
    );

    function automatic int ref_decode(input logic [AW-1:0] a);
        for (int j = 0; j < NB; j++) begin
            if (start_a[j] <= a && a <= end_a[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive_slaves_random();
        for (int j = 0; j < NB; j++) prdata_i[j*DW +: DW] = $urandom;
        pready_i  = NB'($urandom);
        pslverr_i = NB'($urandom);
    endtask

    // Master/slave transaction from master SETUP (n=0) to the response cycle, checked every cycle.
    task automatic run_xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                            input int waits, input logic slverr, input logic [DW-1:0] rdata,
                            input logic drop_psel, input string tag);
        int            k;
        bit            hit, to_hit;
        int            resp_n;
        logic [NB-1:0] kbit, exp_sel, exp_en;
        logic [NB*AW-1:0] exp_addr;
        logic [NB*DW-1:0] exp_wd;
        logic          exp_rdy, exp_err;
        logic [DW-1:0] exp_rd;
        k    = ref_decode(addr);
        hit  = (k >= 0);
        kbit = hit ? (NB'(1) << k) : '0;
`ifdef APB_NODE_TIMEOUT_EN
        to_hit = hit && (waits >= TO);
`else
        to_hit = 1'b0;
`endif
        resp_n = !hit ? 1 : (to_hit ? 2 + TO : 3 + waits);
        if (drop_psel) $display("NOTE %s: master drops psel mid-transfer (illegal APB sequence)", tag);
        for (int n = 0; n <= resp_n; n++) begin
            @(posedge clk_i); #1;
            psel_i    = !(drop_psel && n >= 2);
            penable_i = (n >= 1) && psel_i;
            pwrite_i  = wr;
            paddr_i   = addr;
            pwdata_i  = wdata;
            drive_slaves_random();
            if (hit) begin
                pready_i[k] = 1'b0;
                if (!to_hit && n == 2 + waits) begin
                    pready_i[k]           = 1'b1;
                    pslverr_i[k]          = slverr;
                    prdata_i[k*DW +: DW]  = rdata;
                end
            end
            @(negedge clk_i);
            exp_sel = (n >= 1 && n < resp_n) ? kbit : '0;
            exp_en  = (n >= 2 && n < resp_n) ? kbit : '0;
            exp_rdy = (n == resp_n);
            exp_err = exp_rdy && (!hit || to_hit || slverr);
            exp_rd  = (exp_rdy && hit && !to_hit && !wr) ? rdata : '0;
            for (int j = 0; j < NB; j++) begin
                exp_addr[j*AW +: AW] = exp_sel[j] ? addr : '0;
                exp_wd[j*DW +: DW]   = exp_sel[j] ? wdata : '0;
            end
            n_checks++; if (psel_o !== exp_sel) begin n_errors++; $display("FAIL %s c%0d psel_o got %h exp %h", tag, n, psel_o, exp_sel); end
            n_checks++; if (penable_o !== exp_en) begin n_errors++; $display("FAIL %s c%0d penable_o got %h exp %h", tag, n, penable_o, exp_en); end
            n_checks++; if (pwrite_o !== (wr ? exp_sel : '0)) begin n_errors++; $display("FAIL %s c%0d pwrite_o got %h exp %h", tag, n, pwrite_o, wr ? exp_sel : '0); end
            n_checks++; if (paddr_o !== exp_addr) begin n_errors++; $display("FAIL %s c%0d paddr_o got %h exp %h", tag, n, paddr_o, exp_addr); end
            n_checks++; if (pwdata_o !== exp_wd) begin n_errors++; $display("FAIL %s c%0d pwdata_o got %h exp %h", tag, n, pwdata_o, exp_wd); end
            n_checks++; if (pready_o !== exp_rdy) begin n_errors++; $display("FAIL %s c%0d pready_o got %b exp %b", tag, n, pready_o, exp_rdy); end
            n_checks++; if (pslverr_o !== exp_err) begin n_errors++; $display("FAIL %s c%0d pslverr_o got %b exp %b", tag, n, pslverr_o, exp_err); end
            n_checks++; if (prdata_o !== exp_rd) begin n_errors++; $display("FAIL %s c%0d prdata_o got %h exp %h", tag, n, prdata_o, exp_rd); end
        end
    endtask

    task automatic idle_cycles(input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk_i); #1;
            psel_i    = 1'b0;
            penable_i = 1'b0;
            paddr_i   = $urandom;
            drive_slaves_random();
            @(negedge clk_i);
            n_checks++; if (psel_o !== '0) begin n_errors++; $display("FAIL %s idle psel_o got %h exp 0", tag, psel_o); end
            n_checks++; if (pready_o !== 1'b0) begin n_errors++; $display("FAIL %s idle pready_o got %b exp 0", tag, pready_o); end
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        rst_ni    = 1'b0;
        @(posedge clk_i); #1;
        rst_ni    = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = '0; pwdata_i = '0;
        prdata_i = '0; pready_i = '0; pslverr_i = '0;
        start_a = '{32'h0000_0000, 32'h0000_1000, 32'h0000_4000, 32'h0000_2000,
                    32'h0000_3000, 32'h0000_4000, 32'h0000_9000, 32'hFFFF_FFF0};
        end_a   = '{32'h0000_0FFF, 32'h0000_1FFF, 32'h0000_4FFF, 32'h0000_2FFF,
                    32'h0000_3FFF, 32'h0000_5FFF, 32'h0000_8000, 32'hFFFF_FFFF};
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++; if (psel_o !== '0) begin n_errors++; $display("FAIL reset psel_o got %h exp 0", psel_o); end
        n_checks++; if (penable_o !== '0) begin n_errors++; $display("FAIL reset penable_o got %h exp 0", penable_o); end
        n_checks++; if (pready_o !== 1'b0) begin n_errors++; $display("FAIL reset pready_o got %b exp 0", pready_o); end
        n_checks++; if (pslverr_o !== 1'b0) begin n_errors++; $display("FAIL reset pslverr_o got %b exp 0", pslverr_o); end
        n_checks++; if (prdata_o !== '0) begin n_errors++; $display("FAIL reset prdata_o got %h exp 0", prdata_o); end
        n_checks++; if (paddr_o !== '0) begin n_errors++; $display("FAIL reset paddr_o got %h exp 0", paddr_o); end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_zero_wait_read();
        run_xfer(32'h0000_1004, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, "zero_wait_rd");
        idle_cycles(1, "zero_wait_rd");
    endtask

    task automatic test_overlap_priority();
        run_xfer(32'h0000_4000, 1'b1, 32'hA5A5_A5A5, 0, 1'b0, 32'h1111_2222, 1'b0, "overlap_wr");
        run_xfer(32'h0000_5000, 1'b0, 32'h0, 1, 1'b0, 32'h3333_4444, 1'b0, "overlap_upper");
        idle_cycles(1, "overlap");
    endtask

    task automatic test_decode_miss();
        run_xfer(32'hFFFF_0000, 1'b0, 32'h0, 0, 1'b0, 32'h5555_5555, 1'b0, "miss_rd");
        run_xfer(32'h0000_8800, 1'b1, 32'h7777_7777, 0, 1'b0, 32'h0, 1'b0, "inverted_slot");
        idle_cycles(1, "miss");
    endtask

    task automatic test_wait_error();
        run_xfer(32'h0000_0010, 1'b0, 32'h0, 3, 1'b1, 32'hCAFE_F00D, 1'b0, "wait_err_rd");
        run_xfer(32'h0000_3008, 1'b1, 32'h0BAD_0BAD, 2, 1'b1, 32'h9999_9999, 1'b0, "wait_err_wr");
        idle_cycles(1, "wait_err");
    endtask

    task automatic test_boundaries();
        logic [AW-1:0] bnd [9];
        bnd = '{32'h0000_1000, 32'h0000_1FFF, 32'h0000_0FFF, 32'h0000_5FFF, 32'h0000_6000,
                32'hFFFF_FFFF, 32'hFFFF_FFEF, 32'h0000_8000, 32'h0000_9000};
        for (int i = 0; i < 9; i++) begin
            run_xfer(bnd[i], i[0], $urandom, i % 3, 1'b0, $urandom, 1'b0, $sformatf("boundary%0d", i));
        end
        idle_cycles(1, "boundary");
    endtask

    task automatic test_illegal_start();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            psel_i = 1'b1; penable_i = 1'b1; pwrite_i = 1'b0; paddr_i = 32'h0000_1004;
            drive_slaves_random();
            @(negedge clk_i);
            n_checks++; if (psel_o !== '0) begin n_errors++; $display("FAIL illegal_start psel_o got %h exp 0", psel_o); end
            n_checks++; if (pready_o !== 1'b0) begin n_errors++; $display("FAIL illegal_start pready_o got %b exp 0", pready_o); end
        end
        run_xfer(32'h0000_2004, 1'b0, 32'h0, 0, 1'b0, 32'h2468_ACE0, 1'b0, "after_illegal");
        idle_cycles(1, "illegal_start");
    endtask

    task automatic test_psel_drop();
        run_xfer(32'h0000_1800, 1'b0, 32'h0, 2, 1'b0, 32'h1357_9BDF, 1'b1, "psel_drop");
        idle_cycles(1, "psel_drop");
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       a = AW'($urandom_range(0, 32'h5FFF));
                1:       a = AW'($urandom_range(32'h8000, 32'h9000));
                2:       a = 32'hFFFF_FFF0 | AW'($urandom_range(0, 15));
                3:       a = AW'($urandom_range(32'h6000, 32'h7FFF));
                default: a = $urandom;
            endcase
            run_xfer(a, 1'($urandom), $urandom, $urandom_range(0, 3), 1'($urandom), $urandom, 1'b0,
                     $sformatf("rand%0d", i));
            if ($urandom_range(0, 3) == 0) idle_cycles(1, "rand_gap");
        end
    endtask

    task automatic test_timeout();
`ifdef APB_NODE_TIMEOUT_EN
        run_xfer(32'h0000_2010, 1'b0, 32'h0, 50, 1'b0, 32'h1234_5678, 1'b0, "timeout_rd");
        run_xfer(32'h0000_2020, 1'b0, 32'h0, TO - 1, 1'b1, 32'h8765_4321, 1'b0, "timeout_ready_wins");
        idle_cycles(1, "timeout");
`else
        bit seen_rdy = 1'b0;
        bit bad_en   = 1'b0;
        for (int n = 0; n < 1003; n++) begin
            @(posedge clk_i); #1;
            psel_i = 1'b1; penable_i = (n >= 1); pwrite_i = 1'b0; paddr_i = 32'h0000_2010;
            drive_slaves_random();
            pready_i[3] = 1'b0;
            @(negedge clk_i);
            if (pready_o) seen_rdy = 1'b1;
            if (n >= 2 && penable_o !== 8'h08) bad_en = 1'b1;
        end
        n_checks++; if (seen_rdy) begin n_errors++; $display("FAIL no_timeout pready_o seen got 1 exp 0"); end
        n_checks++; if (bad_en) begin n_errors++; $display("FAIL no_timeout penable_o held got dropped exp 08"); end
        do_reset();
        idle_cycles(1, "no_timeout");
`endif
    endtask

    task automatic test_reset_mid_access_b2b();
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 32'h0000_0100; pwdata_i = 32'hFEED_FACE;
        drive_slaves_random(); pready_i[0] = 1'b0;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        drive_slaves_random(); pready_i[0] = 1'b0;
        @(posedge clk_i); #1;
        drive_slaves_random(); pready_i[0] = 1'b0;
        @(negedge clk_i);
        n_checks++; if (penable_o !== 8'h01) begin n_errors++; $display("FAIL rst_mid pre penable_o got %h exp 01", penable_o); end
        #1 rst_ni = 1'b0;
        #1;
        n_checks++; if (psel_o !== '0) begin n_errors++; $display("FAIL rst_mid psel_o got %h exp 0", psel_o); end
        n_checks++; if (penable_o !== '0) begin n_errors++; $display("FAIL rst_mid penable_o got %h exp 0", penable_o); end
        n_checks++; if (pwrite_o !== '0) begin n_errors++; $display("FAIL rst_mid pwrite_o got %h exp 0", pwrite_o); end
        n_checks++; if (paddr_o !== '0) begin n_errors++; $display("FAIL rst_mid paddr_o got %h exp 0", paddr_o); end
        n_checks++; if (pwdata_o !== '0) begin n_errors++; $display("FAIL rst_mid pwdata_o got %h exp 0", pwdata_o); end
        n_checks++; if (pready_o !== 1'b0) begin n_errors++; $display("FAIL rst_mid pready_o got %b exp 0", pready_o); end
        psel_i = 1'b0; penable_i = 1'b0;
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
        run_xfer(32'h0000_1040, 1'b0, 32'h0, 0, 1'b0, 32'hAAAA_5555, 1'b0, "b2b_first");
        run_xfer(32'h0000_3040, 1'b1, 32'h5A5A_1234, 1, 1'b0, 32'h0, 1'b0, "b2b_second");
        run_xfer(32'h0000_7000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, "b2b_miss");
        run_xfer(32'h0000_0200, 1'b0, 32'h0, 0, 1'b1, 32'h0F0F_0F0F, 1'b0, "b2b_after_miss");
        idle_cycles(2, "b2b");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait_read();
        test_overlap_priority();
        test_decode_miss();
        test_wait_error();
        test_boundaries();
        test_illegal_start();
        test_psel_drop();
        test_random();
        test_timeout();
        test_reset_mid_access_b2b();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
